// File: rtl/uart_rx_ram_ctrl_if.sv
// RAM and uart_tx side bundle for uart_rx_ram_ctrl.
// master = controller (drives the RAM ports and the tx request),
// slave  = RAM/uart_tx side (returns read data and the busy flag).
interface uart_rx_ram_ctrl_if #(
    parameter int ADDR_W = 4
) ();
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        ram_wdata;
    logic [ADDR_W-1:0] ram_raddr;
    logic [7:0]        ram_rdata;
    logic [7:0]        tx_data_o;
    logic              tx_start;
    logic              tx_busy;

    modport master (
        output ram_we, ram_waddr, ram_wdata, ram_raddr, tx_data_o, tx_start,
        input  ram_rdata, tx_busy
    );

    modport slave (
        input  ram_we, ram_waddr, ram_wdata, ram_raddr, tx_data_o, tx_start,
        output ram_rdata, tx_busy
    );
endinterface

// File: rtl/uart_rx_ram_ctrl.sv
// uart_rx_ram_ctrl: stores a received UART frame in a dual-port RAM and,
// once the line has been idle long enough, echoes the frame back to uart_tx.
// Optional feature macro: UART_RAM_LEN_PREFIX_EN -- when defined the echo is
// preceded by a length byte {3'b0, frame_len}.
//
// state   | meaning
// S_IDLE  | waiting for the first byte of a frame
// S_WRITE | collecting bytes, watching for the idle timeout
// S_LEN   | (prefix build only) load the length byte for transmit
// S_RD    | present rd_ptr to the RAM read port
// S_RDW   | RAM data valid, latch it into tx_data_o
// S_TXREQ | wait for uart_tx free, pulse tx_start
// S_TXW   | wait for tx_busy to rise and fall, then advance
module uart_rx_ram_ctrl #(
    parameter int ADDR_W     = 4,
    parameter int IDLE_TICKS = 24
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic                    bps_clk_up,
    input  logic [7:0]              rx_data_i,
    input  logic                    rx_idle,
    input  logic                    rx_bits_ok,
    uart_rx_ram_ctrl_if.master      bus,
    output logic [ADDR_W:0]         frame_len,
    output logic                    overflow
);
    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam int              IW      = $clog2(IDLE_TICKS + 1);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [IW-1:0]   IDLE_TC = IW'(IDLE_TICKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
`ifdef UART_RAM_LEN_PREFIX_EN
        S_LEN,
`endif
        S_RD,
        S_RDW,
        S_TXREQ,
        S_TXW
    } state_t;

    state_t            state, state_nxt;
    logic              rx_bits_ok_d;
    logic              accept;
    logic [IW-1:0]     idle_cnt;
    logic [ADDR_W:0]   rd_ptr;
    logic              busy_seen;
    logic              tx_done;
    logic              tx_start_c;
    logic              ram_we_r;
    logic [ADDR_W-1:0] ram_waddr_r;
    logic [7:0]        ram_wdata_r;
    logic [7:0]        tx_data_r;
`ifdef UART_RAM_LEN_PREFIX_EN
    logic              len_pending;
`endif

    assign accept        = rx_bits_ok & ~rx_bits_ok_d;
    assign tx_done       = busy_seen & ~bus.tx_busy;
    assign bus.ram_we    = ram_we_r;
    assign bus.ram_waddr = ram_waddr_r;
    assign bus.ram_wdata = ram_wdata_r;
    assign bus.ram_raddr = rd_ptr[ADDR_W-1:0];
    assign bus.tx_data_o = tx_data_r;
    assign bus.tx_start  = tx_start_c;

    // State register
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and the single-cycle tx_start request
    always_comb begin
        state_nxt  = state;
        tx_start_c = 1'b0;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_WRITE;
            S_WRITE: if (!accept && idle_cnt == IDLE_TC) begin
`ifdef UART_RAM_LEN_PREFIX_EN
                state_nxt = S_LEN;
`else
                state_nxt = S_RD;
`endif
            end
`ifdef UART_RAM_LEN_PREFIX_EN
            S_LEN:   state_nxt = S_TXREQ;
`endif
            S_RD:    state_nxt = S_RDW;
            S_RDW:   state_nxt = S_TXREQ;
            S_TXREQ: if (!bus.tx_busy) begin
                tx_start_c = 1'b1;
                state_nxt  = S_TXW;
            end
            S_TXW:   if (tx_done) begin
`ifdef UART_RAM_LEN_PREFIX_EN
                if (len_pending)                  state_nxt = S_RD;
                else
`endif
                if (rd_ptr + 1'b1 == frame_len)   state_nxt = S_IDLE;
                else                              state_nxt = S_RD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Byte capture, RAM write port, idle timer, read pointer and tx data
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_bits_ok_d <= 1'b0;
            ram_we_r     <= 1'b0;
            ram_waddr_r  <= '0;
            ram_wdata_r  <= '0;
            tx_data_r    <= '0;
            frame_len    <= '0;
            overflow     <= 1'b0;
            idle_cnt     <= '0;
            rd_ptr       <= '0;
            busy_seen    <= 1'b0;
`ifdef UART_RAM_LEN_PREFIX_EN
            len_pending  <= 1'b0;
`endif
        end else begin
            rx_bits_ok_d <= rx_bits_ok;
            ram_we_r     <= 1'b0;
            // bytes arriving while the echo is running are lost
            if (accept && state != S_IDLE && state != S_WRITE) overflow <= 1'b1;
            case (state)
                S_IDLE: if (accept) begin
                    ram_we_r    <= 1'b1;
                    ram_waddr_r <= '0;
                    ram_wdata_r <= rx_data_i;
                    frame_len   <= (ADDR_W + 1)'(1);
                    overflow    <= 1'b0;
                    idle_cnt    <= '0;
                end
                S_WRITE: begin
                    if (accept) begin
                        idle_cnt <= '0;
                        if (frame_len < DEPTH_L) begin
                            ram_we_r    <= 1'b1;
                            ram_waddr_r <= frame_len[ADDR_W-1:0];
                            ram_wdata_r <= rx_data_i;
                            frame_len   <= frame_len + 1'b1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end else if (idle_cnt == IDLE_TC) begin
                        idle_cnt <= '0;
                        rd_ptr   <= '0;
                    end else if (!rx_idle) begin
                        idle_cnt <= '0;
                    end else if (bps_clk_up) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
`ifdef UART_RAM_LEN_PREFIX_EN
                S_LEN: begin
                    tx_data_r   <= 8'(frame_len);
                    len_pending <= 1'b1;
                end
`endif
                S_RDW:   tx_data_r <= bus.ram_rdata;
                S_TXREQ: busy_seen <= 1'b0;
                S_TXW: begin
                    if (bus.tx_busy) busy_seen <= 1'b1;
                    if (tx_done) begin
                        busy_seen <= 1'b0;
`ifdef UART_RAM_LEN_PREFIX_EN
                        if (len_pending) len_pending <= 1'b0;
                        else
`endif
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_ram_ctrl.sv
// Bench for uart_rx_ram_ctrl: RAM and uart_tx models, random and directed
// frames, expected writes/echo derived from the frame contents alone.
module tb_uart_rx_ram_ctrl;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    typedef logic [7:0] byte_q_t[$];

    logic              sys_clk    = 1'b0;
    logic              rst_n      = 1'b0;
    logic              bps_clk_up = 1'b0;
    logic [7:0]        rx_data_i  = 8'h00;
    logic              rx_idle    = 1'b1;
    logic              rx_bits_ok = 1'b0;
    logic [ADDR_W:0]   frame_len;
    logic              overflow;

    int                n_vec = 0;
    int                n_err = 0;
    int                tick_div = 0;
    int                busy_cnt = 0;
    int                wr_q[$];
    logic [7:0]        tx_q[$];
    logic [7:0]        mem[DEPTH];

    uart_rx_ram_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    uart_rx_ram_ctrl #(.ADDR_W(ADDR_W), .IDLE_TICKS(24)) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .bps_clk_up (bps_clk_up),
        .rx_data_i  (rx_data_i),
        .rx_idle    (rx_idle),
        .rx_bits_ok (rx_bits_ok),
        .bus        (bus),
        .frame_len  (frame_len),
        .overflow   (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    // one baud tick every 8 clocks
    always @(posedge sys_clk) begin
        tick_div   <= (tick_div == 7) ? 0 : tick_div + 1;
        bps_clk_up <= (tick_div == 7);
    end

    // simple dual-port RAM, one cycle read latency, never cleared
    always @(posedge sys_clk) begin
        if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_raddr];
    end

    // uart_tx model: busy the cycle after tx_start, for a random time
    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.tx_busy <= 1'b0;
            busy_cnt    <= 0;
        end else if (bus.tx_start) begin
            bus.tx_busy <= 1'b1;
            busy_cnt    <= int'($urandom_range(1, 12));
        end else if (bus.tx_busy) begin
            if (busy_cnt == 0) bus.tx_busy <= 1'b0;
            else               busy_cnt    <= busy_cnt - 1;
        end
    end

    // observed RAM writes and transmitted bytes
    always @(negedge sys_clk) begin
        if (rst_n && bus.ram_we)   wr_q.push_back(int'(bus.ram_waddr) * 256 + int'(bus.ram_wdata));
        if (rst_n && bus.tx_start) tx_q.push_back(bus.tx_data_o);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input bit exp_we);
        rx_idle = 1'b0;
        repeat (10) @(negedge sys_clk);
        rx_data_i  = b;
        rx_bits_ok = 1'b1;
        @(negedge sys_clk);
        chk("we_latency", 32'(bus.ram_we), 32'(exp_we));
        for (int i = 1; i < hold; i++) begin
            @(negedge sys_clk);
            if (i == 1) chk("we_single", 32'(bus.ram_we), 32'd0);
        end
        rx_bits_ok = 1'b0;
        rx_idle    = 1'b1;
    endtask

    // gap_mode: 0 none, 1 random short or max-length, 2 always 23 ticks
    task automatic run_frame(input byte_q_t data, input int hold_lo, input int hold_hi, input int gap_mode);
        int n, n_st, waited, gap;
        byte_q_t exp_tx;
        n    = data.size();
        n_st = (n > DEPTH) ? DEPTH : n;
        wr_q.delete();
        tx_q.delete();
        for (int i = 0; i < n; i++) begin
            send_byte(data[i], int'($urandom_range(hold_lo, hold_hi)), i < DEPTH);
            if (i != n - 1) begin
                if (gap_mode == 2)      gap = 23;
                else if (gap_mode == 1) gap = ($urandom_range(0, 7) == 0) ? 23 : int'($urandom_range(0, 4));
                else                    gap = 0;
                repeat (gap * 8) @(negedge sys_clk);
            end
        end
`ifdef UART_RAM_LEN_PREFIX_EN
        exp_tx.push_back(8'(n_st));
`endif
        for (int i = 0; i < n_st; i++) exp_tx.push_back(data[i]);
        waited = 0;
        while (tx_q.size() < exp_tx.size() && waited < 4000) begin
            @(negedge sys_clk);
            waited++;
        end
        repeat (40) @(negedge sys_clk);
        chk("wr_count", 32'(wr_q.size()), 32'(n_st));
        for (int i = 0; i < n_st && i < wr_q.size(); i++)
            chk("wr_addr_data", 32'(wr_q[i]), 32'(i * 256 + int'(data[i])));
        chk("tx_count", 32'(tx_q.size()), 32'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
            chk("tx_byte", 32'(tx_q[i]), 32'(exp_tx[i]));
        chk("frame_len", 32'(frame_len), 32'(n_st));
        chk("overflow", 32'(overflow), 32'(n > DEPTH));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
        chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
        chk("rst_waddr", 32'(bus.ram_waddr), 32'd0);
        chk("rst_wdata", 32'(bus.ram_wdata), 32'd0);
        chk("rst_raddr", 32'(bus.ram_raddr), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data_o), 32'd0);
        chk("rst_frame_len", 32'(frame_len), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t d;
        int      waited;

        rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);

        // basic three-byte frame
        d = '{8'h0F, 8'h1D, 8'h48};
        run_frame(d, 1, 1, 1);

        // back-to-back bytes
        d.delete();
        for (int i = 0; i < 6; i++) d.push_back(8'($urandom));
        run_frame(d, 1, 1, 0);

        // 17 bytes: last one dropped, no address wrap
        d.delete();
        for (int i = 0; i <= 16; i++) d.push_back(8'(i));
        run_frame(d, 1, 2, 0);

        // exactly full, no overflow
        d.delete();
        for (int i = 0; i < 16; i++) d.push_back(8'($urandom));
        run_frame(d, 1, 3, 0);

        // level-held rx_bits_ok and maximum in-frame idle gap
        d = '{8'h5A, 8'hC3, 8'h7E};
        run_frame(d, 5, 5, 2);

        // two-byte frame (length prefix visible in the prefix build)
        d = '{8'hBC, 8'h3D};
        run_frame(d, 1, 1, 0);

        // reset during echo
        wr_q.delete();
        tx_q.delete();
        send_byte(8'h11, 1, 1'b1);
        send_byte(8'h22, 1, 1'b1);
        send_byte(8'h33, 1, 1'b1);
        waited = 0;
        while (tx_q.size() < 1 && waited < 4000) begin
            @(negedge sys_clk);
            waited++;
        end
        chk("echo_started", 32'(tx_q.size() >= 1), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        repeat (3) @(negedge sys_clk);
        chk("rst_hold_tx_start", 32'(bus.tx_start), 32'd0);
        rst_n = 1'b1;
        tx_q.delete();
        repeat (300) @(negedge sys_clk);
        chk("no_tx_after_rst", 32'(tx_q.size()), 32'd0);
        d = '{8'hA5};
        run_frame(d, 1, 1, 0);

        // random frames
        for (int f = 0; f < 6; f++) begin
            d.delete();
            for (int i = 0; i < int'($urandom_range(1, 18)); i++) d.push_back(8'($urandom));
            run_frame(d, 1, 4, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
